fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the program memory.

---
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that sits directly in front of a synchronous program
//   memory with 1-cycle read latency. The memory samples the address at posedge
//   and returns the word during the following cycle. This block drives that
//   address and pairs each returned word with the PC it was fetched from.
//
//   Behaviour summary:
//     - Decode stalls hold the in-flight word. To keep it stable, the address of
//       that word is presented to pmem again.
//     - A branch redirect is taken in the same cycle. The target goes straight to
//       pmem, so no extra bubble is inserted.
//     - A saturating counter tracks how many instructions decode has accepted.
//
//   Ports:
//     clock           - single clock; all state changes on posedge
//     reset           - asynchronous, active-high
//     in_stall        - decode cannot accept out_instr this cycle
//     in_redirect     - branch taken: refetch from in_redirect_pc
//     in_redirect_pc  - redirect target (byte address; low bits are ignored)
//     in_pmem_word    - pmem read data for the address sampled at the last edge
//     out_pmem_addr   - byte address to pmem (combinational)
//     out_pc          - PC of out_instr
//     out_instr       - fetched instruction (pass-through of in_pmem_word)
//     out_valid       - out_pc/out_instr are valid
//     out_fetch_count - instructions accepted by decode, saturating
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    WORD_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_stall,
    input  logic                  in_redirect,
    input  logic [ADDR_WIDTH-1:0] in_redirect_pc,
    input  logic [WORD_WIDTH-1:0] in_pmem_word,
    output logic [ADDR_WIDTH-1:0] out_pmem_addr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [WORD_WIDTH-1:0] out_instr,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  out_fetch_count
);

    // Bytes per instruction. This is assumed to be a power of two.
    localparam int                    STEP       = WORD_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] STEP_A     = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    // BOOT covers the single cycle after reset, when pmem has not yet been
    // given an address, so nothing valid is on in_pmem_word.
    typedef enum logic {BOOT, RUN} fsm_t;

    fsm_t                  fsm, fsm_next;
    logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;   // next sequential address
    logic [ADDR_WIDTH-1:0] issued_pc, issued_pc_next; // address pmem sampled last edge
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic [ADDR_WIDTH-1:0] target;

    // NOTE: sequential state uses non-blocking assignments. Every register sees
    // pre-edge values, and this block has no ordering dependency on the others.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm       <= BOOT;
            fetch_pc  <= RESET_PC;
            issued_pc <= RESET_PC;
            count     <= '0;
        end else begin
            fsm       <= fsm_next;
            fetch_pc  <= fetch_pc_next;
            issued_pc <= issued_pc_next;
            count     <= count_next;
        end
    end

    // NOTE: each output of this block gets a default before any branch. If a
    // path left one unassigned, a latch would be inferred.
    always_comb begin
        fsm_next       = fsm;
        fetch_pc_next  = fetch_pc;
        issued_pc_next = issued_pc;
        count_next     = count;
        target         = in_redirect_pc & ALIGN_MASK;

        if (in_redirect) begin
            // Squash the word currently on the bus and restart at the target.
            // A redirect has priority over a stall.
            issued_pc_next = target;
            fetch_pc_next  = target + STEP_A;
            fsm_next       = RUN;
        end else if (fsm == BOOT) begin
            issued_pc_next = fetch_pc;
            fetch_pc_next  = fetch_pc + STEP_A;
            fsm_next       = RUN;
        end else if (!in_stall) begin
            issued_pc_next = fetch_pc;
            fetch_pc_next  = fetch_pc + STEP_A;
            if (count != CNT_MAX) begin
                count_next = count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        out_valid = (fsm == RUN) && !in_redirect;
        if (in_redirect) begin
            out_pmem_addr = target;
        end else if (in_stall && fsm == RUN) begin
            // Present the held word's address again, so pmem keeps returning it.
            out_pmem_addr = issued_pc;
        end else begin
            out_pmem_addr = fetch_pc;
        end
    end

    assign out_pc          = issued_pc;
    assign out_instr       = in_pmem_word;
    assign out_fetch_count = count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit from a behavioural program memory.
//
//   The reference model keeps only three things:
//     - whether a word is flowing yet,
//     - the PC of the word on the bus,
//     - the accepted count.
//   Expected outputs are derived from these, and one compare process checks them
//   every cycle. Directed scenarios pin the model with literal values. These are
//   followed by a random phase and a long run that takes the counter into
//   saturation.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [11:0] RPC = 12'h000;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic [15:0] pmem_word;
    logic [11:0] pmem_addr;
    logic [11:0] pc;
    logic [15:0] instr;
    logic        valid;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .WORD_WIDTH(16), .ADDR_WIDTH(12), .RESET_PC(RPC), .CNT_WIDTH(16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_stall       (stall),
        .in_redirect    (redirect),
        .in_redirect_pc (redirect_pc),
        .in_pmem_word   (pmem_word),
        .out_pmem_addr  (pmem_addr),
        .out_pc         (pc),
        .out_instr      (instr),
        .out_valid      (valid),
        .out_fetch_count(fetch_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Synchronous pmem with 1-cycle latency (16-bit words, byte addressed).
    always @(posedge clock) pmem_word <= mem[pmem_addr[11:1]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_run;   // a word is flowing from pmem
    logic [11:0] m_pc;    // PC of the word currently on the bus
    logic [15:0] m_cnt;

    function automatic logic [11:0] align(input logic [11:0] a);
        return a & 12'hFFE;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_run = 1'b0;
            m_pc  = RPC;
            m_cnt = 16'h0;
        end else if (redirect) begin
            m_pc  = align(redirect_pc);
            m_run = 1'b1;
        end else if (!m_run) begin
            m_pc  = RPC;
            m_run = 1'b1;
        end else if (!stall) begin
            m_pc = m_pc + 12'd2;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            logic [11:0] exp_addr;
            logic        exp_valid;
            exp_valid = m_run && !redirect;
            if (redirect)      exp_addr = align(redirect_pc);
            else if (!m_run)   exp_addr = RPC;
            else if (stall)    exp_addr = m_pc;
            else               exp_addr = m_pc + 12'd2;
            check("m_valid", 32'(valid), 32'(exp_valid));
            check("m_pc",    32'(pc), 32'(m_pc));
            check("m_addr",  32'(pmem_addr), 32'(exp_addr));
            check("m_count", 32'(fetch_count), 32'(m_cnt));
            if (exp_valid) check("m_instr", 32'(instr), 32'(mem[m_pc[11:1]]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic [11:0] t);
        stall       = s;
        redirect    = r;
        redirect_pc = t;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 12'h0);
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Reset release and sequential fetch.
        #1;
        check("c0_valid", 32'(valid), 0);
        check("c0_addr",  32'(pmem_addr), 0);
        check("c0_count", 32'(fetch_count), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            check("seq_pc",    32'(pc), 32'(2 * i));
            check("seq_instr", 32'(instr), 32'h0000A000 + 32'(i));
            check("seq_valid", 32'(valid), 1);
            if (i < 3) tick();
        end
        check("seq_count", 32'(fetch_count), 3);

        // Redirect to an unaligned target while out_pc=6.
        drive(1'b0, 1'b1, 12'h101);
        #1;
        check("redir_valid", 32'(valid), 0);
        check("redir_addr",  32'(pmem_addr), 32'h100);
        tick();
        drive(1'b0, 1'b0, 12'h0);
        #1;
        check("redir_pc0",   32'(pc), 32'h100);
        check("redir_cnt0",  32'(fetch_count), 3);
        tick();
        #1;
        check("redir_pc1",   32'(pc), 32'h102);
        check("redir_cnt1",  32'(fetch_count), 4);

        // Stall for 3 cycles while out_pc=4.
        drive(1'b0, 1'b1, 12'h004);
        tick();
        drive(1'b1, 1'b0, 12'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_pc",    32'(pc), 4);
            check("stall_addr",  32'(pmem_addr), 4);
            check("stall_instr", 32'(instr), 32'hA002);
            check("stall_cnt",   32'(fetch_count), 4);
            tick();
        end
        stall = 1'b0;
        #1;
        check("resume_pc4", 32'(pc), 4);
        tick();
        #1;
        check("resume_pc6", 32'(pc), 6);
        check("resume_cnt", 32'(fetch_count), 5);
        tick();
        #1;
        check("resume_pc8", 32'(pc), 8);
        check("resume_cnt2", 32'(fetch_count), 6);

        // Redirect and stall together: the redirect wins.
        drive(1'b1, 1'b1, 12'h040);
        #1;
        check("rs_valid", 32'(valid), 0);
        check("rs_addr",  32'(pmem_addr), 32'h40);
        tick();
        drive(1'b0, 1'b0, 12'h0);
        #1;
        check("rs_pc",    32'(pc), 32'h40);
        check("rs_valid1", 32'(valid), 1);
        check("rs_cnt",   32'(fetch_count), 6);

        // Sequential fetch across the top of the address space.
        drive(1'b0, 1'b1, 12'hFFC);
        tick();
        drive(1'b0, 1'b0, 12'h0);
        tick();
        #1;
        check("wrap_ffe", 32'(pc), 32'hFFE);
        tick();
        #1;
        check("wrap_000", 32'(pc), 0);
        check("wrap_val", 32'(valid), 1);
        check("wrap_addr", 32'(pmem_addr), 2);
        check("wrap_cnt", 32'(fetch_count), 8);

        // Reset asserted mid-run at out_pc=0x20.
        drive(1'b0, 1'b1, 12'h01C);
        tick();
        drive(1'b0, 1'b0, 12'h0);
        tick();
        tick();
        #1;
        check("mid_pc20", 32'(pc), 32'h20);
        reset = 1'b1;
        #1;
        check("mid_valid", 32'(valid), 0);
        check("mid_count", 32'(fetch_count), 0);
        check("mid_pc",    32'(pc), 32'(RPC));
        tick();
        reset = 1'b0;
        #1;
        check("rel_valid", 32'(valid), 0);
        check("rel_addr",  32'(pmem_addr), 32'(RPC));
        tick();
        #1;
        check("rel_pc",    32'(pc), 32'(RPC));
        check("rel_valid1", 32'(valid), 1);
        check("rel_count", 32'(fetch_count), 0);

        // Random stall / redirect / reset traffic, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive(1'b0, 1'b0, 12'h0);
                reset_pulse();
            end else begin
                drive(1'b0, 1'b0, 12'h0);
                stall       = ($urandom_range(0, 99) < 30);
                redirect    = ($urandom_range(0, 99) < 10);
                redirect_pc = 12'($urandom_range(0, 4095));
                tick();
            end
        end

        // Run the counter into saturation: cycle k after release holds k-1.
        drive(1'b0, 1'b0, 12'h0);
        reset_pulse();
        for (int k = 1; k <= 65535; k++) tick();
        #1;
        check("sat_fffe", 32'(fetch_count), 32'hFFFE);
        repeat (3) tick();
        #1;
        check("sat_ffff", 32'(fetch_count), 32'hFFFF);
        tick();
        #1;
        check("sat_hold", 32'(fetch_count), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
